lut_neuron_ram: RTL
===================

# lut_neuron_ram

Runtime-loadable LUT neuron: a 2^IN_BITS x OUT_BITS distributed-RAM truth table that is written by a streaming configuration port and then answers registered lookups. It is the write-side counterpart of the fixed per-neuron ROM modules generated for each layer. The same table contents (entry k = neuron output for packed input k) can be loaded at bring-up or reloaded between inference runs without resynthesis.

## Interface
- IN_BITS, default 8: packed neuron input width; table depth 2^IN_BITS (256).
- OUT_BITS, default 2: neuron output width per entry.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  configuration beat present.
- cfg_data  in  OUT_BITS  table entry for the current write address.
- cfg_last  in  1  marks the final beat of a table load.
- cfg_ready  out  1  block accepts configuration beats.
- cfg_clear  in  1  single-cycle pulse: discard the table, return to LOAD.
- cfg_done  out  1  table fully and correctly loaded (level).
- cfg_err  out  1  sticky framing error from the last load attempt.
- in_valid  in  1  lookup request.
- in_data  in  IN_BITS  packed neuron input, used directly as table address.
- out_valid  out  1  lookup result valid.
- out_data  out  OUT_BITS  table entry for the registered request.

## Operation
- States: LOAD, RUN. Reset enters LOAD with wr_addr=0.
- Beat accepted when cfg_valid && cfg_ready. The beat writes mem[wr_addr] = cfg_data. Entries arrive in ascending address order, 0 first.
- LOAD, accepted beat, wr_addr < 2^IN_BITS-1, cfg_last=0: wr_addr++.
- LOAD, accepted beat, wr_addr == 2^IN_BITS-1, cfg_last=1: go to RUN, cfg_done=1, cfg_err=0, wr_addr=0.
- Framing error: cfg_last=1 at wr_addr < max, or cfg_last=0 at wr_addr == max. The beat is still written, then cfg_err=1, wr_addr=0, and the block stays in LOAD. The next beat restarts the load at address 0.
- cfg_err clears only on reset or on a successful load.
- RUN: cfg_ready=0, and cfg_valid is ignored.
- cfg_clear in any state: go to LOAD, wr_addr=0, cfg_done=0. cfg_err is unchanged. Any beat in the same cycle is dropped. cfg_clear wins over a simultaneous final beat.
- Lookup: in RUN, in_valid captures mem[in_data]. In LOAD, in_valid is ignored and out_valid stays 0.
- No backpressure on the lookup path: one lookup per cycle, every cycle.
- mem is not reset. Contents persist across cfg_clear and are overwritten only by new beats.

## Timing
- Reset values: cfg_ready=0, cfg_done=0, cfg_err=0, out_valid=0, out_data=0, state=LOAD, wr_addr=0.
- cfg_ready is a register. It rises on the first clk edge after rst deasserts, so no beat is accepted in that first cycle.
- Full load takes 2^IN_BITS accepted beats. Idle cycles (cfg_valid=0) are allowed anywhere and do not advance wr_addr.
- cfg_ready and cfg_done change on the edge that accepts the final beat, so the next cycle shows cfg_ready=0 and cfg_done=1.
- Lookup latency is 1 cycle: in_valid/in_data sampled at edge N gives out_valid/out_data at edge N. They are visible during cycle N+1.
- out_valid=0 drops out_data to 0 (out_data is registered and zeroed when out_valid=0).
- A lookup accepted in the same cycle as cfg_clear is served, because state is still RUN at that edge.
- Asynchronous rst mid-load or mid-lookup forces all reset values immediately. A partial load is abandoned.

## Test plan
- Reset, then load 256 beats with entry k = k[1:0] and cfg_last on beat 255 -> cfg_done=1 and cfg_ready=0 the next cycle, cfg_err=0. Then lookups 0x00, 0x55, 0xFF on consecutive cycles -> out_data 0,1,3 with out_valid=1, each one cycle after its request.
- Load the fixed layer-0 neuron-85 truth table. Sweep in_data 0..255 back-to-back -> every out_data matches the corresponding ROM entry (e.g. 0x10->2'b10, 0x08->2'b00, 0x00->2'b01) with 1-cycle latency and no bubbles.
- cfg_last asserted on beat 100 -> cfg_err=1, cfg_done=0, block stays in LOAD. A following clean 256-beat load -> cfg_done=1, cfg_err=0.
- Beat 255 sent without cfg_last -> cfg_err=1, wr_addr back to 0. in_valid during LOAD -> out_valid stays 0.
- After a good load, pulse cfg_clear together with in_valid, in_data=0x3C -> that lookup returns its entry. cfg_done=0 and cfg_ready=1 the next cycle.
- cfg_clear coincident with the final beat -> block stays in LOAD, cfg_done=0. Separately, assert rst at beat 128 -> all outputs 0 immediately, and after release a fresh load starts at address 0.

Source files
------------

// File: rtl/lut_neuron_ram.sv
// ---------------------------------------------------------------------------
// lut_neuron_ram
// Runtime-loadable LUT neuron. A 2^IN_BITS x OUT_BITS truth table is filled
// by a streaming configuration port (ascending addresses, 0 first, cfg_last
// on the final entry) and then answers one registered lookup per cycle.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-high reset
//   cfg_valid  in   configuration beat present
//   cfg_data   in   table entry for the current write address
//   cfg_last   in   final beat of a table load
//   cfg_ready  out  block accepts configuration beats (registered)
//   cfg_clear  in   single-cycle pulse: discard table, return to LOAD
//   cfg_done   out  table fully and correctly loaded (level)
//   cfg_err    out  sticky framing error from the last load attempt
//   in_valid   in   lookup request
//   in_data    in   packed neuron input, used as table address
//   out_valid  out  lookup result valid
//   out_data   out  table entry for the registered request (0 when idle)
// ---------------------------------------------------------------------------
module lut_neuron_ram #(
   parameter int unsigned IN_BITS  = 8,
   parameter int unsigned OUT_BITS = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_valid,
   input  logic [OUT_BITS-1:0] cfg_data,
   input  logic                cfg_last,
   output logic                cfg_ready,
   input  logic                cfg_clear,
   output logic                cfg_done,
   output logic                cfg_err,
   input  logic                in_valid,
   input  logic [IN_BITS-1:0]  in_data,
   output logic                out_valid,
   output logic [OUT_BITS-1:0] out_data
);

   localparam int unsigned        DEPTH     = 1 << IN_BITS;
   localparam logic [IN_BITS-1:0] LAST_ADDR = '1;

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Registered state
   state_t               r_state;
   logic [IN_BITS-1:0]   r_wr_addr;
   logic                 r_cfg_ready;
   logic                 r_cfg_done;
   logic                 r_cfg_err;
   logic                 r_out_valid;
   logic [OUT_BITS-1:0]  r_out_data;

   // Truth table storage; intentionally not reset so contents survive clears
   logic [OUT_BITS-1:0]  r_mem [DEPTH];

   // Next-state values
   state_t               w_state_nxt;
   logic [IN_BITS-1:0]   w_wr_addr_nxt;
   logic                 w_cfg_ready_nxt;
   logic                 w_cfg_done_nxt;
   logic                 w_cfg_err_nxt;

   logic                 w_beat;
   logic                 w_at_last;
   logic                 w_lookup;

   // A clear in the same cycle drops any beat, including a final one
   assign w_beat    = cfg_valid & r_cfg_ready & ~cfg_clear;
   assign w_at_last = (r_wr_addr == LAST_ADDR);
   // State is sampled before any same-cycle clear takes effect
   assign w_lookup  = in_valid & (r_state == ST_RUN);

   // Next-state and status logic
   always_comb begin
      w_state_nxt     = r_state;
      w_wr_addr_nxt   = r_wr_addr;
      w_cfg_ready_nxt = r_cfg_ready;
      w_cfg_done_nxt  = r_cfg_done;
      w_cfg_err_nxt   = r_cfg_err;

      if (cfg_clear) begin
         w_state_nxt     = ST_LOAD;
         w_wr_addr_nxt   = '0;
         w_cfg_ready_nxt = 1'b1;
         w_cfg_done_nxt  = 1'b0;
      end else begin
         case (r_state)
            ST_LOAD: begin
               // Ready rises on the first edge after reset release
               w_cfg_ready_nxt = 1'b1;
               if (w_beat) begin
                  if (w_at_last && cfg_last) begin
                     w_state_nxt     = ST_RUN;
                     w_wr_addr_nxt   = '0;
                     w_cfg_ready_nxt = 1'b0;
                     w_cfg_done_nxt  = 1'b1;
                     w_cfg_err_nxt   = 1'b0;
                  end else if (w_at_last || cfg_last) begin
                     // Framing error: beat is kept, load restarts at 0
                     w_wr_addr_nxt = '0;
                     w_cfg_err_nxt = 1'b1;
                  end else begin
                     w_wr_addr_nxt = r_wr_addr + IN_BITS'(1);
                  end
               end
            end
            ST_RUN: begin
               w_cfg_ready_nxt = 1'b0;
            end
            default: begin
               w_state_nxt     = ST_LOAD;
               w_wr_addr_nxt   = '0;
               w_cfg_ready_nxt = 1'b0;
               w_cfg_done_nxt  = 1'b0;
            end
         endcase
      end
   end

   // State, status and lookup output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_LOAD;
         r_wr_addr   <= '0;
         r_cfg_ready <= 1'b0;
         r_cfg_done  <= 1'b0;
         r_cfg_err   <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_wr_addr   <= w_wr_addr_nxt;
         r_cfg_ready <= w_cfg_ready_nxt;
         r_cfg_done  <= w_cfg_done_nxt;
         r_cfg_err   <= w_cfg_err_nxt;
         r_out_valid <= w_lookup;
         r_out_data  <= w_lookup ? r_mem[in_data] : '0;
      end
   end

   // Table write port
   always_ff @(posedge clk) begin
      if (w_beat) begin
         r_mem[r_wr_addr] <= cfg_data;
      end
   end

   assign cfg_ready = r_cfg_ready;
   assign cfg_done  = r_cfg_done;
   assign cfg_err   = r_cfg_err;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;

endmodule
